// File: rtl/ni_flit_injector_if.sv
// ni_flit_injector_if
// Bundles the packetizer-side flit stream, the router-side flit/valid/VC link,
// the per-VC credit-return and VC-free lines, and the status outputs of
// ni_flit_injector.
//   master : the injector itself (takes src_*, iack, irdy; drives the rest)
//   slave  : the environment (packetizer + router input channel)
// Parameters:
//   DATAW : flit MSB index (flit is DATAW+1 bits, type in [DATAW:DATAW-1])
//   VCN   : number of virtual channels
//   VW    : width of a VC index
interface ni_flit_injector_if #(
  parameter int DATAW = 15,
  parameter int VCN   = 2,
  parameter int VW    = (VCN > 1) ? $clog2(VCN) : 1
);
  logic [DATAW:0]  src_data;
  logic            src_valid;
  logic            src_ready;
  logic [DATAW:0]  odata;
  logic            ovalid;
  logic [VW-1:0]   ovch;
  logic [VCN-1:0]  iack;
  logic [VCN-1:0]  irdy;
  logic            busy;
  logic            err;
  logic [15:0]     flit_cnt;

  modport master (
    input  src_data, src_valid, iack, irdy,
    output src_ready, odata, ovalid, ovch, busy, err, flit_cnt
  );

  modport slave (
    output src_data, src_valid, iack, irdy,
    input  src_ready, odata, ovalid, ovch, busy, err, flit_cnt
  );
endinterface

// File: rtl/ni_flit_injector.sv
// ni_flit_injector
// Feeds a router local input channel from the network-interface packetizer.
// Each packet is bound to the lowest free VC that has credit; flits are then
// forwarded on that VC with per-VC credit flow control. The output link is
// registered (one cycle latency).
// Ports:
//   clk  : clock
//   rst_ : asynchronous active-high reset
//   bus  : ni_flit_injector_if.master
//          src_data/src_valid/src_ready : flit stream from packetizer
//          odata/ovalid/ovch            : flit link to router input channel
//          iack  : per-VC one-cycle credit return
//          irdy  : per-VC "free for a new packet"
//          busy  : packet in progress
//          err   : sticky protocol error (orphan body/tail, nested head,
//                  credit overflow)
//          flit_cnt : sent-flit counter, wraps
module ni_flit_injector #(
  parameter int DATAW   = 15,
  parameter int VCN     = 2,
  parameter int CREDITS = 4,
  parameter int CW      = 3,
  parameter int VW      = (VCN > 1) ? $clog2(VCN) : 1
) (
  input  logic                 clk,
  input  logic                 rst_,
  ni_flit_injector_if.master   bus
);

  localparam logic [0:0]    S_IDLE   = 1'b0;
  localparam logic [0:0]    S_ACTIVE = 1'b1;
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  logic [0:0]     state_q, state_d;
  logic [VW-1:0]  cur_vc_q, cur_vc_d;
  logic [CW-1:0]  credit_q [VCN];
  logic [CW-1:0]  credit_d [VCN];
  logic [VCN-1:0] has_cred;
  logic [VCN-1:0] avail;
  logic [VCN-1:0] ovf;

  logic           any_avail;
  logic [VW-1:0]  sel_vc;
  logic           ready;
  logic           send;
  logic           drop;
  logic [VW-1:0]  send_vc;

  logic [DATAW:0] odata_q;
  logic           ovalid_q;
  logic [VW-1:0]  ovch_q;
  logic           err_q;
  logic [15:0]    flit_cnt_q;

  logic [1:0]     ftype;
  logic           is_hs;     // head or single-flit: starts a packet
  logic           is_head;
  logic           is_tail;

  assign ftype   = bus.src_data[DATAW:DATAW-1];
  assign is_hs   = ~ftype[1];
  assign is_head = (ftype == 2'b01);
  assign is_tail = (ftype == 2'b11);

  // Per-VC credit bookkeeping. A send and a credit return in the same cycle
  // cancel. A return with the counter already full is a protocol error and
  // is discarded so the counter can never exceed the buffer depth.
  for (genvar gi = 0; gi < VCN; gi++) begin : g_vc
    logic dec;
    logic inc;
    assign dec          = send && (send_vc == VW'(gi));
    assign inc          = bus.iack[gi];
    assign has_cred[gi] = (credit_q[gi] != '0);
    assign avail[gi]    = bus.irdy[gi] & has_cred[gi];
    assign ovf[gi]      = inc & ~dec & (credit_q[gi] == CRED_MAX);
    assign credit_d[gi] = (dec && !inc)                ? credit_q[gi] - 1'b1 :
                          (inc && !dec && !ovf[gi])     ? credit_q[gi] + 1'b1 :
                                                          credit_q[gi];
  end

  // Lowest-index VC that is free and has credit (scan downward so the
  // last hit is the lowest index).
  always_comb begin
    any_avail = 1'b0;
    sel_vc    = '0;
    for (int v = VCN - 1; v >= 0; v--) begin
      if (avail[v]) begin
        any_avail = 1'b1;
        sel_vc    = VW'(v);
      end
    end
  end

  // Accept/forward decision. Depends only on registered state, registered
  // credits and irdy, so a same-cycle iack never opens the gate.
  always_comb begin
    state_d  = state_q;
    cur_vc_d = cur_vc_q;
    ready    = 1'b0;
    send     = 1'b0;
    drop     = 1'b0;
    send_vc  = cur_vc_q;
    if (bus.src_valid) begin
      if (state_q == S_IDLE) begin
        if (is_hs) begin
          if (any_avail) begin
            ready   = 1'b1;
            send    = 1'b1;
            send_vc = sel_vc;
            if (is_head) begin
              state_d  = S_ACTIVE;
              cur_vc_d = sel_vc;
            end
          end
        end else begin
          // body/tail with no open packet: swallow it and flag
          ready = 1'b1;
          drop  = 1'b1;
        end
      end else begin
        if (!is_hs) begin
          // irdy is deliberately ignored mid-packet
          ready = has_cred[cur_vc_q];
          send  = has_cred[cur_vc_q];
          if (has_cred[cur_vc_q] && is_tail) begin
            state_d = S_IDLE;
          end
        end else begin
          // new packet start while one is open: swallow, keep current packet
          ready = 1'b1;
          drop  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state_q    <= S_IDLE;
      cur_vc_q   <= '0;
      odata_q    <= '0;
      ovalid_q   <= 1'b0;
      ovch_q     <= '0;
      err_q      <= 1'b0;
      flit_cnt_q <= '0;
      for (int v = 0; v < VCN; v++) begin
        credit_q[v] <= CRED_MAX;
      end
    end else begin
      state_q  <= state_d;
      cur_vc_q <= cur_vc_d;
      ovalid_q <= send;
      if (send) begin
        odata_q    <= bus.src_data;
        ovch_q     <= send_vc;
        flit_cnt_q <= flit_cnt_q + 16'd1;
      end
      err_q <= err_q | drop | (|ovf);
      for (int v = 0; v < VCN; v++) begin
        credit_q[v] <= credit_d[v];
      end
    end
  end

  // Held low throughout reset even though the reset state would allow it.
  assign bus.src_ready = ready & ~rst_;
  assign bus.odata     = odata_q;
  assign bus.ovalid    = ovalid_q;
  assign bus.ovch      = ovch_q;
  assign bus.busy      = (state_q == S_ACTIVE);
  assign bus.err       = err_q;
  assign bus.flit_cnt  = flit_cnt_q;

endmodule

// File: tb/tb_ni_flit_injector.sv
module tb_ni_flit_injector;

  localparam int DATAW   = 15;
  localparam int VCN     = 2;
  localparam int CREDITS = 4;
  localparam int CW      = 3;
  localparam int VW      = 1;

  typedef struct {
    logic [15:0] data;
    logic        valid;
    logic [1:0]  iack;
    logic [1:0]  irdy;
    logic        rdy;   // expected src_ready before the edge
    logic        ov;    // expected ovalid after the edge
    logic        ch;    // expected ovch after the edge (checked when ov)
    logic        busy;
    logic        err;
    logic [15:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_;
  int   total = 0;
  int   bad   = 0;

  ni_flit_injector_if #(.DATAW(DATAW), .VCN(VCN), .VW(VW)) bus_if ();

  ni_flit_injector #(
    .DATAW(DATAW), .VCN(VCN), .CREDITS(CREDITS), .CW(CW), .VW(VW)
  ) dut (
    .clk (clk),
    .rst_(rst_),
    .bus (bus_if.master)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [15:0] data, input logic valid,
                              input logic [1:0] iack, input logic [1:0] irdy,
                              input logic rdy, input logic ov, input logic ch,
                              input logic busy, input logic err,
                              input logic [15:0] cnt);
    vec_t v;
    v.data = data; v.valid = valid; v.iack = iack; v.irdy = irdy;
    v.rdy = rdy; v.ov = ov; v.ch = ch; v.busy = busy; v.err = err; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called one time unit after a rising edge: drive, check ready, clock,
  // check registered outputs.
  task automatic apply(input vec_t v, input string tag);
    bus_if.src_data  = v.data;
    bus_if.src_valid = v.valid;
    bus_if.iack      = v.iack;
    bus_if.irdy      = v.irdy;
    #2;
    chk({tag, ".src_ready"}, 32'(bus_if.src_ready), 32'(v.rdy));
    @(posedge clk);
    #1;
    bus_if.src_valid = 1'b0;
    bus_if.iack      = '0;
    chk({tag, ".ovalid"}, 32'(bus_if.ovalid), 32'(v.ov));
    if (v.ov) begin
      chk({tag, ".ovch"},  32'(bus_if.ovch),  32'(v.ch));
      chk({tag, ".odata"}, 32'(bus_if.odata), 32'(v.data));
    end
    chk({tag, ".busy"},     32'(bus_if.busy),     32'(v.busy));
    chk({tag, ".err"},      32'(bus_if.err),      32'(v.err));
    chk({tag, ".flit_cnt"}, 32'(bus_if.flit_cnt), 32'(v.cnt));
    $display("%s data=%h valid=%0b iack=%b irdy=%b -> ready=%0b ovalid=%0b ovch=%0d busy=%0b err=%0b cnt=%0d",
             tag, v.data, v.valid, v.iack, v.irdy, v.rdy, bus_if.ovalid,
             bus_if.ovch, bus_if.busy, bus_if.err, bus_if.flit_cnt);
  endtask

  // Leaves the bench one time unit after a rising edge, reset released.
  task automatic do_reset();
    rst_             = 1'b1;
    bus_if.src_valid = 1'b0;
    bus_if.src_data  = '0;
    bus_if.iack      = '0;
    bus_if.irdy      = '0;
    repeat (2) @(posedge clk);
    #3 rst_ = 1'b0;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [17];
  int   exp_c0;

  initial begin
    // type: 0x4 head, 0x8 body, 0xC tail, 0x0 single
    tbl[0]  = mk(16'h4A00, 1, 2'b00, 2'b11, 1, 1, 0, 1, 0, 16'd1);
    tbl[1]  = mk(16'h8A01, 1, 2'b00, 2'b11, 1, 1, 0, 1, 0, 16'd2);
    tbl[2]  = mk(16'h8A02, 1, 2'b00, 2'b11, 1, 1, 0, 1, 0, 16'd3);
    tbl[3]  = mk(16'hCA03, 1, 2'b00, 2'b11, 1, 1, 0, 0, 0, 16'd4);
    tbl[4]  = mk(16'h0000, 0, 2'b00, 2'b11, 0, 0, 0, 0, 0, 16'd4);
    // VC0 exhausted -> single goes to VC1
    tbl[5]  = mk(16'h0B05, 1, 2'b00, 2'b11, 1, 1, 1, 0, 0, 16'd5);
    tbl[6]  = mk(16'h0B06, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 16'd5);
    // same-cycle iack does not enable the accept
    tbl[7]  = mk(16'h0B07, 1, 2'b01, 2'b01, 0, 0, 0, 0, 0, 16'd5);
    tbl[8]  = mk(16'h0B08, 1, 2'b00, 2'b01, 1, 1, 0, 0, 0, 16'd6);
    tbl[9]  = mk(16'h4C09, 1, 2'b00, 2'b10, 1, 1, 1, 1, 0, 16'd7);
    // irdy drop mid-packet ignored
    tbl[10] = mk(16'h8C0A, 1, 2'b00, 2'b00, 1, 1, 1, 1, 0, 16'd8);
    // head while ACTIVE: dropped, err
    tbl[11] = mk(16'h4C0B, 1, 2'b00, 2'b00, 1, 0, 0, 1, 1, 16'd8);
    // send + iack on VC1 same cycle: credit stays 1
    tbl[12] = mk(16'h8C0C, 1, 2'b10, 2'b00, 1, 1, 1, 1, 1, 16'd9);
    tbl[13] = mk(16'h8C0D, 1, 2'b00, 2'b00, 1, 1, 1, 1, 1, 16'd10);
    tbl[14] = mk(16'hCC0E, 1, 2'b00, 2'b00, 0, 0, 0, 1, 1, 16'd10);
    tbl[15] = mk(16'hCC0F, 1, 2'b10, 2'b00, 0, 0, 0, 1, 1, 16'd10);
    tbl[16] = mk(16'hCC10, 1, 2'b00, 2'b00, 1, 1, 1, 0, 1, 16'd11);

    // reset state while rst_ high, with an eligible head offered
    rst_             = 1'b1;
    bus_if.src_data  = 16'h4123;
    bus_if.src_valid = 1'b1;
    bus_if.iack      = '0;
    bus_if.irdy      = 2'b11;
    #3;
    chk("rst.src_ready", 32'(bus_if.src_ready), 32'd0);
    chk("rst.ovalid",    32'(bus_if.ovalid),    32'd0);
    chk("rst.odata",     32'(bus_if.odata),     32'd0);
    chk("rst.busy",      32'(bus_if.busy),      32'd0);
    chk("rst.err",       32'(bus_if.err),       32'd0);
    chk("rst.flit_cnt",  32'(bus_if.flit_cnt),  32'd0);
    do_reset();

    for (int i = 0; i < 17; i++) begin
      apply(tbl[i], $sformatf("tbl%0d", i));
      if (i == 4) begin
        chk("tbl.credit0_after_pkt", 32'(dut.credit_q[0]), 32'd0);
        chk("tbl.credit1_untouched", 32'(dut.credit_q[1]), 32'd4);
      end
    end

    // body in IDLE: dropped, err
    do_reset();
    apply(mk(16'h8D00, 1, 2'b00, 2'b11, 1, 0, 0, 0, 1, 16'd0), "orphan_body");

    // credit overflow on VC1
    do_reset();
    apply(mk(16'h0000, 0, 2'b10, 2'b11, 0, 0, 0, 0, 1, 16'd0), "ovf_iack1");
    chk("ovf.credit1", 32'(dut.credit_q[1]), 32'd4);

    // 6-flit packet against 4 credits, iack after a stall
    do_reset();
    apply(mk(16'h4E00, 1, 2'b00, 2'b01, 1, 1, 0, 1, 0, 16'd1), "stall_f1");
    apply(mk(16'h8E01, 1, 2'b00, 2'b01, 1, 1, 0, 1, 0, 16'd2), "stall_f2");
    apply(mk(16'h8E02, 1, 2'b00, 2'b01, 1, 1, 0, 1, 0, 16'd3), "stall_f3");
    apply(mk(16'h8E03, 1, 2'b00, 2'b01, 1, 1, 0, 1, 0, 16'd4), "stall_f4");
    apply(mk(16'h8E04, 1, 2'b00, 2'b01, 0, 0, 0, 1, 0, 16'd4), "stall_wait");
    apply(mk(16'h8E04, 1, 2'b01, 2'b01, 0, 0, 0, 1, 0, 16'd4), "stall_iack");
    apply(mk(16'h8E04, 1, 2'b00, 2'b01, 1, 1, 0, 1, 0, 16'd5), "stall_f5");
    apply(mk(16'hCE05, 1, 2'b00, 2'b01, 0, 0, 0, 1, 0, 16'd5), "stall_tail");
    exp_c0 = CREDITS - 5 + 1;  // five sends, one return
    chk("stall.credit0", 32'(dut.credit_q[0]), 32'(exp_c0));

    // reset between flit 2 and flit 3
    do_reset();
    apply(mk(16'h4F00, 1, 2'b00, 2'b11, 1, 1, 0, 1, 0, 16'd1), "midrst_f1");
    apply(mk(16'h8F01, 1, 2'b00, 2'b11, 1, 1, 0, 1, 0, 16'd2), "midrst_f2");
    bus_if.src_data  = 16'h8F02;
    bus_if.src_valid = 1'b1;
    bus_if.irdy      = 2'b11;
    #2 rst_ = 1'b1;
    #1;
    chk("midrst.src_ready", 32'(bus_if.src_ready), 32'd0);
    chk("midrst.ovalid",    32'(bus_if.ovalid),    32'd0);
    chk("midrst.odata",     32'(bus_if.odata),     32'd0);
    chk("midrst.ovch",      32'(bus_if.ovch),      32'd0);
    chk("midrst.busy",      32'(bus_if.busy),      32'd0);
    chk("midrst.flit_cnt",  32'(bus_if.flit_cnt),  32'd0);
    $display("midrst asserted: ready=%0b ovalid=%0b busy=%0b cnt=%0d",
             bus_if.src_ready, bus_if.ovalid, bus_if.busy, bus_if.flit_cnt);
    bus_if.src_valid = 1'b0;
    @(posedge clk);
    #3 rst_ = 1'b0;
    @(posedge clk);
    #1;
    apply(mk(16'h4F10, 1, 2'b00, 2'b11, 1, 1, 0, 1, 0, 16'd1), "midrst_new_head");
    chk("midrst.credit0", 32'(dut.credit_q[0]), 32'd3);
    chk("midrst.credit1", 32'(dut.credit_q[1]), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
